pmem_controller: RTL and testbench
==================================

PMEM_CONTROLLER -- requirements
Module: pmem_controller

Interface
REQ-001 Parameter BEATS, default 8, SHALL set the 16-bit memory beats per 128-bit line.
REQ-002 Parameter BEAT_W, default 3, SHALL set the beat-counter width (log2 BEATS).
REQ-003 Port CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port RST  in  1  SHALL be the reset, asynchronous and active-high.
REQ-005 Port wb  wishbone.slave  --  SHALL carry CYC, STB, WE in 1; SEL in 16; ADR in 12 (line address); DAT_M in 128; DAT_S out 128; ACK out 1; RTY out 1.
REQ-006 Port mem_req  out  1  SHALL request one memory beat.
REQ-007 Port mem_we  out  1  SHALL mark the beat as a write.
REQ-008 Port mem_addr  out  15  SHALL be the word address {ADR, beat}.
REQ-009 Port mem_be  out  2  SHALL carry byte enables for write beats.
REQ-010 Port mem_wdata  out  16  SHALL carry write data.
REQ-011 Port mem_rdata  in  16  SHALL carry read data, valid with mem_rdy.
REQ-012 Port mem_rdy  in  1  SHALL complete the current beat when high with mem_req.

Function
REQ-013 FSM states SHALL be IDLE, READ, WRITE, RESP.
REQ-014 IDLE: on CYC&STB, latch ADR, WE, SEL, DAT_M; go to WRITE if WE, else READ; beat counter := 0.
REQ-015 READ: mem_req=1, mem_we=0, mem_addr={ADR,beat}; on mem_rdy, store mem_rdata in line[16*beat+:16], beat++; after beat BEATS-1 completes, go to RESP.
REQ-016 READ SHALL ignore SEL; every beat is fetched.
REQ-017 WRITE: per beat, mem_be=SEL[2*beat+:2], mem_wdata=DAT_M[16*beat+:16], mem_we=1.
REQ-018 WRITE beats with mem_be==2'b00 SHALL be skipped in one cycle with mem_req=0.
REQ-019 WRITE beats with nonzero mem_be SHALL hold mem_req until mem_rdy, then advance; after the last beat go to RESP.
REQ-020 RESP SHALL last exactly one cycle with ACK=1; DAT_S = assembled line on reads and is don't-care on writes; next state IDLE.
REQ-021 ACK SHALL be registered, high only in RESP, one cycle per accepted request.
REQ-022 The master drops STB on the edge where it samples ACK; IDLE SHALL accept a new request in the cycle right after RESP.
REQ-023 STB/CYC deassertion mid-transaction SHALL be ignored; the transaction runs to RESP.
REQ-024 mem_addr, mem_we, mem_be, mem_wdata SHALL stay stable while mem_req=1 and mem_rdy=0.
REQ-025 RTY SHALL be tied 0.
REQ-026 Minimum latency: read = BEATS+2 cycles from STB to ACK with mem_rdy always high; all-zero-SEL write = BEATS+2 cycles with no mem_req.

Reset
REQ-027 RST SHALL force IDLE asynchronously, including mid-transaction; the in-flight request is dropped with no ACK.
REQ-028 During and after reset, ACK, mem_req, mem_we, mem_be, and the beat counter SHALL be 0; the line buffer and DAT_S SHALL be 128'h0.

Structure
REQ-029 lc3b_types SHALL hold PMEM_BEATS=8 and the typedefs lc3b_pmem_line (128b), lc3b_pmem_sel (16b), lc3b_pmem_word_addr (15b).
REQ-030 The FSM and beat counter SHALL live inline; one sub-module, pmem_line_buffer (beat-indexed 16-bit write into a 128-bit register, clearable), SHALL hold the read line.

Verification
REQ-031 Read with ADR=12'h0A3, mem_rdy=1, mem_rdata=beat index -> mem_addr 15'h0518..15'h051F; ACK once at cycle 10; DAT_S=128'h0007_0006_..._0000.
REQ-032 Write with SEL=16'h00F0, DAT_M beats 0xAAAA.. -> mem_req only for beats 2 and 3, mem_be=2'b11; ACK once.
REQ-033 Read with mem_rdy low for 3 cycles on beat 4 -> mem_addr and mem_req held stable; DAT_S correct; ACK delayed by 3 cycles.
REQ-034 RST pulse during beat 5 of a read -> IDLE immediately, mem_req=0, no ACK, DAT_S=0; a following read completes normally.
REQ-035 Back-to-back read then write with STB dropped on ACK -> second request accepted the cycle after RESP; exactly two ACKs.
REQ-036 Write with SEL=16'h0000 -> no mem_req; ACK after 10 cycles.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b physical memory path: line, select and word-address
// shapes plus the state encoding of the memory controller.
package lc3b_types;

    localparam int PMEM_BEATS = 8;

    typedef logic [127:0] lc3b_pmem_line;
    typedef logic [15:0]  lc3b_pmem_sel;
    typedef logic [14:0]  lc3b_pmem_word_addr;
    typedef logic [11:0]  lc3b_pmem_line_addr;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } pmem_state_t;

endpackage

// File: rtl/wishbone.sv
// Line-wide Wishbone bundle between the cache side (master) and the memory
// controller (slave).
interface wishbone;

    logic        CYC;
    logic        STB;
    logic        WE;
    logic [15:0] SEL;
    logic [11:0] ADR;
    logic [127:0] DAT_M;
    logic [127:0] DAT_S;
    logic        ACK;
    logic        RTY;

    modport slave (
        input  CYC, STB, WE, SEL, ADR, DAT_M,
        output DAT_S, ACK, RTY
    );

endinterface

// File: rtl/pmem_line_buffer.sv
// 128-bit line register filled one 16-bit beat at a time; clear wins over load
// so a freshly accepted request always starts from an all-zero line.
module pmem_line_buffer
    import lc3b_types::*;
#(
    parameter int BEAT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [BEAT_W-1:0] beat,
    input  logic [15:0]       din,
    output lc3b_pmem_line     line
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (clear) begin
            line <= '0;
        end else if (load) begin
            line[16*beat +: 16] <= din;
        end
    end

endmodule

// File: rtl/pmem_controller.sv
// Splits one 128-bit Wishbone line access into BEATS 16-bit memory beats and
// answers with a single registered ACK once the whole line has been moved.
module pmem_controller
    import lc3b_types::*;
#(
    parameter int BEATS  = PMEM_BEATS,
    parameter int BEAT_W = 3
) (
    input  logic               CLK,
    input  logic               RST,
    wishbone.slave             wb,
    output logic               mem_req,
    output logic               mem_we,
    output logic [1:0]         mem_be,
    output lc3b_pmem_word_addr mem_addr,
    output logic [15:0]        mem_wdata,
    input  logic [15:0]        mem_rdata,
    input  logic               mem_rdy
);

    pmem_state_t        state;
    pmem_state_t        state_next;
    logic [BEAT_W-1:0]  beat;
    logic [BEAT_W-1:0]  beat_next;
    lc3b_pmem_line_addr adr_q;
    lc3b_pmem_sel       sel_q;
    lc3b_pmem_line      dat_q;
    lc3b_pmem_line      line;
    logic               ack_q;
    logic               accept;
    logic               line_load;
    logic               last_beat;
    logic [1:0]         beat_be;
    logic [15:0]        beat_data;

    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign beat_be   = sel_q[2*beat +: 2];
    assign beat_data = dat_q[16*beat +: 16];
    assign mem_addr  = lc3b_pmem_word_addr'({adr_q, beat});

    assign wb.DAT_S = line;
    assign wb.ACK   = ack_q;
    assign wb.RTY   = 1'b0;

    // ACK is registered from the next state so it is high exactly while in RESP.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            beat  <= '0;
            ack_q <= 1'b0;
            adr_q <= '0;
            sel_q <= '0;
            dat_q <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            ack_q <= (state_next == RESP);
            if (accept) begin
                adr_q <= wb.ADR;
                sel_q <= wb.SEL;
                dat_q <= wb.DAT_M;
            end
        end
    end

    always_comb begin
        state_next = state;
        beat_next  = beat;
        accept     = 1'b0;
        line_load  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 2'b00;
        mem_wdata  = 16'h0000;

        case (state)
            IDLE: begin
                if (wb.CYC && wb.STB) begin
                    accept     = 1'b1;
                    beat_next  = '0;
                    state_next = wb.WE ? WRITE : READ;
                end
            end

            READ: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    line_load = 1'b1;
                    if (last_beat) begin
                        beat_next  = '0;
                        state_next = RESP;
                    end else begin
                        beat_next = beat + 1'b1;
                    end
                end
            end

            // Beats with no enabled bytes never reach memory and cost one cycle.
            WRITE: begin
                mem_we    = 1'b1;
                mem_be    = beat_be;
                mem_wdata = beat_data;
                mem_req   = |beat_be;
                if (!(|beat_be) || mem_rdy) begin
                    if (last_beat) begin
                        beat_next  = '0;
                        state_next = RESP;
                    end else begin
                        beat_next = beat + 1'b1;
                    end
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    pmem_line_buffer #(
        .BEAT_W (BEAT_W)
    ) u_line_buffer (
        .clk   (CLK),
        .rst   (RST),
        .clear (accept),
        .load  (line_load),
        .beat  (beat),
        .din   (mem_rdata),
        .line  (line)
    );

endmodule

// File: tb/tb_pmem_controller.sv
// Directed scoreboard bench for pmem_controller: each request pushes its expected
// line, latency and memory beats; ACKs and memory beats are checked as they appear.
module tb_pmem_controller;
    import lc3b_types::*;

    typedef struct {
        bit            is_read;
        lc3b_pmem_line line;
        int            latency;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mem_req;
    logic               mem_we;
    logic [1:0]         mem_be;
    lc3b_pmem_word_addr mem_addr;
    logic [15:0]        mem_wdata;
    logic [15:0]        mem_rdata;
    logic               mem_rdy;

    exp_t               exp_q[$];
    int                 beat_q[$];
    lc3b_pmem_line_addr cur_adr;
    lc3b_pmem_sel       cur_sel;
    lc3b_pmem_line      cur_dat;
    bit                 cur_we;
    int                 stall_beat;
    int                 stall_left;
    int                 rd_mode = 0;
    int                 checks = 0;
    int                 fails = 0;
    int                 ack_count = 0;
    int                 ack_base;
    bit                 found;

    wishbone wb_if ();

    pmem_controller #(
        .BEATS  (8),
        .BEAT_W (3)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .wb        (wb_if),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy)
    );

    always #5 clk = ~clk;

    // Mode 0 returns the beat index; mode 1 returns an address-dependent pattern.
    always_comb begin
        if (rd_mode == 0) mem_rdata = {13'd0, mem_addr[2:0]};
        else              mem_rdata = {1'b0, mem_addr} ^ 16'hC3A5;
    end

    always @(negedge clk) begin
        if (wb_if.ACK === 1'b1) ack_count++;
    end

    function automatic logic [15:0] rd_model(input int mode, input lc3b_pmem_line_addr adr, input int b);
        if (mode == 0) return 16'(b);
        return {1'b0, adr, 3'(b)} ^ 16'hC3A5;
    endfunction

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic apply_stimulus(input bit we, input lc3b_pmem_line_addr adr, input lc3b_pmem_sel sel,
                                  input lc3b_pmem_line dat, input int sb, input int sc);
        exp_t e;
        cur_we     = we;
        cur_adr    = adr;
        cur_sel    = sel;
        cur_dat    = dat;
        stall_beat = sb;
        stall_left = sc;
        beat_q.delete();
        e.is_read = !we;
        e.line    = '0;
        e.latency = 10 + sc;
        for (int b = 0; b < 8; b++) begin
            if (!we || sel[2*b +: 2] != 2'b00) beat_q.push_back(b);
            e.line[16*b +: 16] = rd_model(rd_mode, adr, b);
        end
        exp_q.push_back(e);
        wb_if.CYC   = 1'b1;
        wb_if.STB   = 1'b1;
        wb_if.WE    = we;
        wb_if.ADR   = adr;
        wb_if.SEL   = sel;
        wb_if.DAT_M = dat;
        $display("[TB] request we=%0b adr=%h sel=%h", we, adr, sel);
    endtask

    task automatic wait_ack(input string tag, input int start_cyc, input bit chain);
        int            cyc = start_cyc;
        bit            stalled = 0;
        bit            done = 0;
        int            b;
        exp_t          e;
        logic [127:0]  obs;
        logic [127:0]  expv;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check_output({tag, "_req_held"}, 128'(mem_req), 128'd1);
                stalled = 0;
            end
            if (wb_if.ACK === 1'b1) begin
                done    = 1;
                mem_rdy = 1'b1;
                if (exp_q.size() == 0) begin
                    check_output({tag, "_unexpected_ack"}, 128'(exp_q.size()), 128'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_output({tag, "_latency"}, 128'(cyc), 128'(e.latency));
                    check_output({tag, "_beats_left"}, 128'(beat_q.size()), 128'd0);
                    if (e.is_read) check_output({tag, "_dat_s"}, wb_if.DAT_S, e.line);
                end
                if (!chain) begin
                    wb_if.CYC = 1'b0;
                    wb_if.STB = 1'b0;
                end
            end else if (mem_req === 1'b1) begin
                if (beat_q.size() == 0) begin
                    check_output({tag, "_extra_req"}, 128'(mem_req), 128'd0);
                    mem_rdy = 1'b1;
                end else begin
                    b = beat_q[0];
                    if (cur_we) begin
                        obs  = 128'({mem_we, mem_addr, mem_be, mem_wdata});
                        expv = 128'({1'b1, cur_adr, 3'(b), cur_sel[2*b +: 2], cur_dat[16*b +: 16]});
                    end else begin
                        obs  = 128'({mem_we, mem_addr});
                        expv = 128'({1'b0, cur_adr, 3'(b)});
                    end
                    check_output({tag, "_beat"}, obs, expv);
                    if (b == stall_beat && stall_left > 0) begin
                        mem_rdy = 1'b0;
                        stall_left--;
                        stalled = 1;
                    end else begin
                        mem_rdy = 1'b1;
                        void'(beat_q.pop_front());
                    end
                end
            end else begin
                mem_rdy = 1'b1;
            end
        end
        if (!done) begin
            check_output({tag, "_ack_timeout"}, 128'(done), 128'd1);
            wb_if.CYC = 1'b0;
            wb_if.STB = 1'b0;
        end
    endtask

    initial begin
        wb_if.CYC   = 1'b0;
        wb_if.STB   = 1'b0;
        wb_if.WE    = 1'b0;
        wb_if.ADR   = '0;
        wb_if.SEL   = '0;
        wb_if.DAT_M = '0;
        mem_rdy     = 1'b1;

        repeat (2) @(negedge clk);
        check_output("reset_ctrl", 128'({wb_if.ACK, mem_req, mem_we, mem_be, mem_addr}), 128'd0);
        check_output("reset_dat_s", wb_if.DAT_S, 128'd0);
        check_output("rty_tied", 128'(wb_if.RTY), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic read, beat-index data");
        apply_stimulus(1'b0, 12'h0A3, 16'hFFFF, '0, -1, 0);
        wait_ack("rd_basic", 1, 1'b0);
        check_output("rd_basic_line", wb_if.DAT_S, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        @(negedge clk);
        #1;
        check_output("rd_basic_ack_once", 128'(wb_if.ACK), 128'd0);

        $display("[TB] sparse write, beats 2 and 3");
        apply_stimulus(1'b1, 12'h3C5, 16'h00F0, 128'hAAA7_AAA6_AAA5_AAA4_AAA3_AAA2_AAA1_AAA0, -1, 0);
        wait_ack("wr_sparse", 1, 1'b0);
        @(negedge clk);

        $display("[TB] read with a three-cycle stall on beat 4");
        rd_mode = 1;
        apply_stimulus(1'b0, 12'hFFF, 16'h0000, '0, 4, 3);
        wait_ack("rd_stall", 1, 1'b0);
        @(negedge clk);

        $display("[TB] mixed-enable write, stall on last beat");
        apply_stimulus(1'b1, 12'h801, 16'h8C01, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 7, 2);
        wait_ack("wr_mixed", 1, 1'b0);
        @(negedge clk);

        $display("[TB] write with no byte enables");
        apply_stimulus(1'b1, 12'h123, 16'h0000, {8{16'hBEEF}}, -1, 0);
        wait_ack("wr_zero", 1, 1'b0);
        @(negedge clk);

        $display("[TB] reset pulse during beat 5 of a read");
        rd_mode = 0;
        apply_stimulus(1'b0, 12'h155, 16'hFFFF, '0, -1, 0);
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_addr[2:0] == 3'd5) found = 1;
        end
        check_output("rst_reached_beat5", 128'(found), 128'd1);
        rst = 1'b1;
        #1;
        check_output("rst_ctrl", 128'({wb_if.ACK, mem_req, mem_we, mem_be, mem_addr}), 128'd0);
        check_output("rst_dat_s", wb_if.DAT_S, 128'd0);
        wb_if.CYC = 1'b0;
        wb_if.STB = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beat_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        ack_base = ack_count;
        repeat (12) @(negedge clk);
        #1;
        check_output("rst_no_ack", 128'(ack_count), 128'(ack_base));
        apply_stimulus(1'b0, 12'h2C4, 16'h0000, '0, -1, 0);
        wait_ack("rd_after_rst", 1, 1'b0);
        @(negedge clk);

        $display("[TB] back-to-back read then write");
        #1;
        ack_base = ack_count;
        rd_mode = 1;
        apply_stimulus(1'b0, 12'h7E1, 16'hFFFF, '0, -1, 0);
        wait_ack("b2b_rd", 1, 1'b1);
        apply_stimulus(1'b1, 12'h7E2, 16'h3000, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, -1, 0);
        wait_ack("b2b_wr", 0, 1'b0);
        @(negedge clk);
        #1;
        check_output("b2b_two_acks", 128'(ack_count), 128'(ack_base + 2));

        check_output("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
